fifo_dma_sched: RTL and testbench

FIFO_DMA_SCHED -- requirements
Module: fifo_dma_sched

---
 rtl/fifo_dma_sched_if.sv | 29 ++
 rtl/fifo_dma_sched.sv | 142 ++++++++++++++
 tb/tb_fifo_dma_sched.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_dma_sched_if.sv
// Handshake and status bundle between the SCSI/memory DMA sequencer and its
// environment: strobes, bus arbitration and FIFO bookkeeping outputs.
interface fifo_dma_sched_if;
   logic       DMADIR;
   logic       DMAENA;
   logic       FLUSH;
   logic       FIFOCLR;
   logic       SSTB;
   logic       MSTB;
   logic       BGRANT;
   logic       BREQ;
   logic [2:0] WPTR;
   logic [2:0] RPTR;
   logic [3:0] COUNT;
   logic       FIFOFULL;
   logic       FIFOEMPTY;
   logic       FLUSHED;
   logic       ERR;

   modport slave (
      input  DMADIR, DMAENA, FLUSH, FIFOCLR, SSTB, MSTB, BGRANT,
      output BREQ, WPTR, RPTR, COUNT, FIFOFULL, FIFOEMPTY, FLUSHED, ERR
   );

   modport master (
      output DMADIR, DMAENA, FLUSH, FIFOCLR, SSTB, MSTB, BGRANT,
      input  BREQ, WPTR, RPTR, COUNT, FIFOFULL, FIFOEMPTY, FLUSHED, ERR
   );
endinterface

// File: rtl/fifo_dma_sched.sv
// 8-entry DMA FIFO pointer/occupancy tracker with a bus-request scheduler that
// moves whole FIFO loads (or a flushed partial load) between SCSI and memory.
module fifo_dma_sched (
   input  logic            CLK,
   input  logic            RST_,
   fifo_dma_sched_if.slave bus
);
   typedef enum logic [1:0] {IDLE, REQ, XFER, RELEASE} state_t;

   state_t     state_q, state_d;
   logic [2:0] wptr_q, wptr_d;
   logic [2:0] rptr_q, rptr_d;
   logic [3:0] count_q, count_d;
   logic       full_q, empty_q;
   logic       breq_q, breq_d;
   logic       err_q, err_d;
   logic       fpend_q, fpend_d;
   logic       flushed_q, flushed_d;
   logic       sstb_acc, mstb_acc, wr, rd, fpend_eff;

   // Memory-side strobes only count while we actually own the bus.
   assign sstb_acc = bus.SSTB & bus.DMAENA;
   assign mstb_acc = bus.MSTB & (state_q == XFER);
   assign wr       = bus.DMADIR ? mstb_acc : sstb_acc;
   assign rd       = bus.DMADIR ? sstb_acc : mstb_acc;

   always_comb begin
      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      count_d = count_q;
      err_d   = err_q;
      if (wr && rd) begin
         if (count_q == 4'd0) begin
            // Nothing to read yet: the write lands, the read is an underrun.
            wptr_d  = wptr_q + 3'd1;
            count_d = 4'd1;
            err_d   = 1'b1;
         end else begin
            wptr_d = wptr_q + 3'd1;
            rptr_d = rptr_q + 3'd1;
         end
      end else if (wr) begin
         if (count_q != 4'd8) begin
            wptr_d  = wptr_q + 3'd1;
            count_d = count_q + 4'd1;
         end else begin
            err_d = 1'b1;
         end
      end else if (rd) begin
         if (count_q != 4'd0) begin
            rptr_d  = rptr_q + 3'd1;
            count_d = count_q - 4'd1;
         end else begin
            err_d = 1'b1;
         end
      end
      if (bus.FIFOCLR) begin
         wptr_d  = 3'd0;
         rptr_d  = 3'd0;
         count_d = 4'd0;
         err_d   = 1'b0;
      end
   end

   always_comb begin
      fpend_eff = fpend_q | (bus.FLUSH & ~bus.DMADIR);
      flushed_d = fpend_eff & (count_d == 4'd0);
      fpend_d   = fpend_eff & (count_d != 4'd0);
      if (bus.FIFOCLR) begin
         flushed_d = 1'b0;
         fpend_d   = 1'b0;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (bus.DMAENA &&
                ((!bus.DMADIR && (full_q || (fpend_q && !empty_q))) ||
                 (bus.DMADIR && empty_q)))
               state_d = REQ;
         end
         REQ: begin
            if (!bus.DMAENA)
               state_d = IDLE;
            else if (bus.BGRANT)
               state_d = XFER;
         end
         XFER: begin
            if (!bus.DMAENA ||
                (!bus.DMADIR && rd && (count_q != 4'd0) && (count_d == 4'd0)) ||
                (bus.DMADIR && wr && (count_q != 4'd8) && (count_d == 4'd8)))
               state_d = RELEASE;
         end
         RELEASE: begin
            if (!bus.BGRANT)
               state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      // A clear while granted must still hand the bus back cleanly.
      if (bus.FIFOCLR)
         state_d = bus.BGRANT ? RELEASE : IDLE;
      breq_d = (state_d == REQ) || (state_d == XFER);
   end

   always_ff @(posedge CLK or negedge RST_) begin
      if (!RST_) begin
         state_q   <= IDLE;
         wptr_q    <= 3'd0;
         rptr_q    <= 3'd0;
         count_q   <= 4'd0;
         full_q    <= 1'b0;
         empty_q   <= 1'b1;
         breq_q    <= 1'b0;
         err_q     <= 1'b0;
         fpend_q   <= 1'b0;
         flushed_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         wptr_q    <= wptr_d;
         rptr_q    <= rptr_d;
         count_q   <= count_d;
         full_q    <= (count_d == 4'd8);
         empty_q   <= (count_d == 4'd0);
         breq_q    <= breq_d;
         err_q     <= err_d;
         fpend_q   <= fpend_d;
         flushed_q <= flushed_d;
      end
   end

   assign bus.BREQ      = breq_q;
   assign bus.WPTR      = wptr_q;
   assign bus.RPTR      = rptr_q;
   assign bus.COUNT     = count_q;
   assign bus.FIFOFULL  = full_q;
   assign bus.FIFOEMPTY = empty_q;
   assign bus.FLUSHED   = flushed_q;
   assign bus.ERR       = err_q;
endmodule

// File: tb/tb_fifo_dma_sched.sv
// Directed bench for fifo_dma_sched: the driver queues hand-computed expected
// status per cycle, an independent monitor compares it on the falling edge.
module tb_fifo_dma_sched;
   logic CLK = 1'b0;
   logic RST_ = 1'b0;
   always #5 CLK = ~CLK;

   fifo_dma_sched_if bus();
   fifo_dma_sched dut (.CLK(CLK), .RST_(RST_), .bus(bus));

   int cyc = 0;
   always @(posedge CLK) cyc <= cyc + 1;

   typedef struct {
      string       name;
      int          cyc;
      logic [14:0] v;
   } exp_t;

   exp_t sb[$];
   int   total = 0;
   int   bad   = 0;
   bit   done  = 1'b0;

   function automatic logic [14:0] pack(logic [3:0] c, logic [2:0] w, logic [2:0] r,
                                        logic b, logic e, logic f);
      return {c, w, r, (c == 4'd8), (c == 4'd0), b, e, f};
   endfunction

   function automatic string fmt(logic [14:0] v);
      return $sformatf("cnt=%0d w=%0d r=%0d full=%b empty=%b breq=%b err=%b flushed=%b",
                       v[14:11], v[10:8], v[7:5], v[4], v[3], v[2], v[1], v[0]);
   endfunction

   task automatic chk(string nm, int c, int w, int r, bit b, bit e, bit f);
      exp_t x;
      x.name = nm;
      x.cyc  = cyc;
      x.v    = pack(4'(c), 3'(w), 3'(r), b, e, f);
      sb.push_back(x);
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
      bus.SSTB    = 1'b0;
      bus.MSTB    = 1'b0;
      bus.FLUSH   = 1'b0;
      bus.FIFOCLR = 1'b0;
   endtask

   initial begin : monitor
      exp_t        e;
      logic [14:0] got;
      forever begin
         @(negedge CLK);
         got = {bus.COUNT, bus.WPTR, bus.RPTR, bus.FIFOFULL, bus.FIFOEMPTY,
                bus.BREQ, bus.ERR, bus.FLUSHED};
         while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            total++;
            if (e.cyc != cyc || got !== e.v) begin
               bad++;
               $display("FAIL %s (cyc %0d, sampled %0d): got %s, want %s",
                        e.name, e.cyc, cyc, fmt(got), fmt(e.v));
            end
         end
         if (done && sb.size() == 0) break;
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin : watchdog
      #100000;
      $display("FAIL watchdog: simulation did not complete, want completion");
      $fatal(1, "watchdog expired");
   end

   initial begin : driver
      bus.DMADIR = 1'b0; bus.DMAENA = 1'b0; bus.FLUSH = 1'b0; bus.FIFOCLR = 1'b0;
      bus.SSTB = 1'b0;   bus.MSTB = 1'b0;   bus.BGRANT = 1'b0;

      // reset: strobes are ignored while held
      tick();
      bus.SSTB = 1'b1; bus.DMAENA = 1'b1;
      tick();
      chk("reset_hold", 0, 0, 0, 0, 0, 0);
      bus.DMAENA = 1'b0;
      RST_ = 1'b1;
      tick();
      chk("after_reset", 0, 0, 0, 0, 0, 0);

      // full load SCSI->memory
      bus.DMADIR = 1'b0; bus.DMAENA = 1'b1;
      for (int i = 0; i < 8; i++) begin
         bus.SSTB = 1'b1; tick();
         chk("a_fill", i + 1, (i + 1) % 8, 0, 0, 0, 0);
      end
      tick();                 chk("a_breq", 8, 0, 0, 1, 0, 0);
      bus.BGRANT = 1'b1;
      tick();                 chk("a_grant", 8, 0, 0, 1, 0, 0);
      for (int i = 0; i < 8; i++) begin
         bus.MSTB = 1'b1; tick();
         chk("a_drain", 7 - i, 0, (i + 1) % 8, (i < 7), 0, 0);
      end
      tick();                 chk("a_release", 0, 0, 0, 0, 0, 0);
      bus.BGRANT = 1'b0;
      tick();                 chk("a_idle", 0, 0, 0, 0, 0, 0);
      bus.MSTB = 1'b1; tick(); chk("a_mstb_ignored", 0, 0, 0, 0, 0, 0);

      // partial load flushed to memory
      for (int i = 0; i < 3; i++) begin
         bus.SSTB = 1'b1; tick();
         chk("b_fill", i + 1, i + 1, 0, 0, 0, 0);
      end
      bus.FLUSH = 1'b1; tick(); chk("b_flush", 3, 3, 0, 0, 0, 0);
      tick();                 chk("b_breq", 3, 3, 0, 1, 0, 0);
      bus.BGRANT = 1'b1;
      tick();                 chk("b_grant", 3, 3, 0, 1, 0, 0);
      for (int i = 0; i < 3; i++) begin
         bus.MSTB = 1'b1; tick();
         chk("b_drain", 2 - i, 3, i + 1, (i < 2), 0, (i == 2));
      end
      tick();                 chk("b_pulse_end", 0, 3, 3, 0, 0, 0);
      bus.BGRANT = 1'b0;
      tick();                 chk("b_idle", 0, 3, 3, 0, 0, 0);
      bus.FLUSH = 1'b1; tick(); chk("b_flush_empty", 0, 3, 3, 0, 0, 1);
      tick();                 chk("b_no_req", 0, 3, 3, 0, 0, 0);

      // memory->SCSI load, drain, then underrun
      bus.DMADIR = 1'b1;
      tick();                 chk("c_breq", 0, 3, 3, 1, 0, 0);
      bus.BGRANT = 1'b1;
      tick();                 chk("c_grant", 0, 3, 3, 1, 0, 0);
      for (int i = 0; i < 8; i++) begin
         bus.MSTB = 1'b1; tick();
         chk("c_fill", i + 1, (4 + i) % 8, 3, (i < 7), 0, 0);
      end
      bus.BGRANT = 1'b0;
      tick();                 chk("c_idle", 8, 3, 3, 0, 0, 0);
      for (int i = 0; i < 8; i++) begin
         bus.SSTB = 1'b1; tick();
         chk("c_read", 7 - i, 3, (4 + i) % 8, 0, 0, 0);
      end
      bus.SSTB = 1'b1; tick(); chk("c_underrun", 0, 3, 3, 1, 1, 0);
      bus.DMAENA = 1'b0;
      tick();                 chk("c_abort", 0, 3, 3, 0, 1, 0);
      bus.FIFOCLR = 1'b1; tick(); chk("c_clr", 0, 0, 0, 0, 0, 0);

      // simultaneous strobes on a full FIFO
      bus.DMADIR = 1'b0; bus.DMAENA = 1'b1;
      for (int i = 0; i < 8; i++) begin
         bus.SSTB = 1'b1; tick();
         chk("d_fill", i + 1, (i + 1) % 8, 0, 0, 0, 0);
      end
      tick();                 chk("d_breq", 8, 0, 0, 1, 0, 0);
      bus.BGRANT = 1'b1;
      tick();                 chk("d_grant", 8, 0, 0, 1, 0, 0);
      bus.SSTB = 1'b1; bus.MSTB = 1'b1;
      tick();                 chk("d_simul_full", 8, 1, 1, 1, 0, 0);
      bus.DMAENA = 1'b0;
      tick();                 chk("d_abort", 8, 1, 1, 0, 0, 0);
      bus.BGRANT = 1'b0;
      tick();                 chk("d_idle", 8, 1, 1, 0, 0, 0);
      bus.FIFOCLR = 1'b1; tick(); chk("d_clr", 0, 0, 0, 0, 0, 0);

      // simultaneous strobes on an empty FIFO
      bus.DMADIR = 1'b1; bus.DMAENA = 1'b1;
      tick();                 chk("e_breq", 0, 0, 0, 1, 0, 0);
      bus.BGRANT = 1'b1;
      tick();                 chk("e_grant", 0, 0, 0, 1, 0, 0);
      bus.SSTB = 1'b1; bus.MSTB = 1'b1;
      tick();                 chk("e_simul_empty", 1, 1, 0, 1, 1, 0);
      bus.DMAENA = 1'b0;
      tick();                 chk("e_abort", 1, 1, 0, 0, 1, 0);
      bus.BGRANT = 1'b0;
      tick();                 chk("e_idle", 1, 1, 0, 0, 1, 0);
      bus.FIFOCLR = 1'b1; tick(); chk("e_clr", 0, 0, 0, 0, 0, 0);

      // soft clear while granted
      bus.DMAENA = 1'b1;
      tick();                 chk("f_breq", 0, 0, 0, 1, 0, 0);
      bus.BGRANT = 1'b1;
      tick();                 chk("f_grant", 0, 0, 0, 1, 0, 0);
      for (int i = 0; i < 4; i++) begin
         bus.MSTB = 1'b1; tick();
         chk("f_fill", i + 1, i + 1, 0, 1, 0, 0);
      end
      bus.FIFOCLR = 1'b1; bus.MSTB = 1'b1; bus.SSTB = 1'b1;
      tick();                 chk("f_clr", 0, 0, 0, 0, 0, 0);
      tick();                 chk("f_release_hold", 0, 0, 0, 0, 0, 0);
      bus.BGRANT = 1'b0;
      tick();                 chk("f_idle", 0, 0, 0, 0, 0, 0);
      tick();                 chk("f_rereq", 0, 0, 0, 1, 0, 0);
      bus.DMAENA = 1'b0;
      tick();                 chk("f_abort", 0, 0, 0, 0, 0, 0);

      // asynchronous reset mid-transfer
      bus.DMAENA = 1'b1;
      tick();                 chk("g_breq", 0, 0, 0, 1, 0, 0);
      bus.BGRANT = 1'b1;
      tick();                 chk("g_grant", 0, 0, 0, 1, 0, 0);
      for (int i = 0; i < 5; i++) begin
         bus.MSTB = 1'b1; tick();
         chk("g_fill", i + 1, i + 1, 0, 1, 0, 0);
      end
      tick();
      #1 RST_ = 1'b0;
      #1 chk("g_async_reset", 0, 0, 0, 0, 0, 0);
      total++;
      if (bus.BREQ !== 1'b0) begin
         bad++;
         $display("FAIL g_async_breq: got breq=%b, want 0", bus.BREQ);
      end
      total++;
      if (bus.COUNT !== 4'd0) begin
         bad++;
         $display("FAIL g_async_count: got cnt=%0d, want 0", bus.COUNT);
      end
      total++;
      if (bus.FIFOEMPTY !== 1'b1) begin
         bad++;
         $display("FAIL g_async_empty: got empty=%b, want 1", bus.FIFOEMPTY);
      end
      bus.SSTB = 1'b1; bus.MSTB = 1'b1;
      tick();                 chk("g_hold_reset", 0, 0, 0, 0, 0, 0);
      RST_ = 1'b1; bus.BGRANT = 1'b0; bus.DMAENA = 1'b0;
      tick();                 chk("g_after", 0, 0, 0, 0, 0, 0);

      done = 1'b1;
   end
endmodule
